// File: rtl/load_store_unit_if.sv
// Core-side request/response and word-memory bus for the load/store unit.
// The master side is the core plus word memory; the slave side is the unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output req_valid, op, addr, wdata, ReadData,
    input  req_ready, resp_valid, resp_err, rdata, MemRead, MemWrite, Address, WriteData
  );

  modport slave (
    input  req_valid, op, addr, wdata, ReadData,
    output req_ready, resp_valid, resp_err, rdata, MemRead, MemWrite, Address, WriteData
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit over a 32-bit word memory.
// Sub-word stores use read-modify-write; misaligned accesses fail without touching memory.
module load_store_unit (
  input  logic             clock,
  input  logic             reset_n,
  load_store_unit_if.slave bus
);
  localparam int DATA_W = 32;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_p0;
  logic [DATA_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic                err_p0;
  logic [DATA_W-1:0]   rdata_p1;
  logic [DATA_W-1:0]   wword_p1;
  logic                acc_err;
  logic                rmw_p0;

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         misaligned = |a;
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      default:              misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] op, input logic [1:0] a,
                                                    input logic [DATA_W-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (op)
      OP_LB:   load_extend = {{24{b[7]}}, b};
      OP_LBU:  load_extend = {24'h0, b};
      OP_LH:   load_extend = {{16{h[15]}}, h};
      OP_LHU:  load_extend = {16'h0, h};
      default: load_extend = w;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(input logic [2:0] op, input logic [1:0] a,
                                                    input logic [DATA_W-1:0] w,
                                                    input logic [DATA_W-1:0] d);
    store_merge = w;
    if (op == OP_SB) store_merge[{a, 3'b000} +: 8]    = d[7:0];
    else             store_merge[{a[1], 4'b0000} +: 16] = d[15:0];
  endfunction

  assign acc_err = misaligned(bus.op, bus.addr[1:0]);
  assign rmw_p0  = (op_p0 == OP_SB) || (op_p0 == OP_SH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (acc_err)               state_d = RESP;
        else if (bus.op == OP_SW)  state_d = WR;
        else                       state_d = RD;
      end
      RD:      state_d = rmw_p0 ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_p0    <= '0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      err_p0   <= 1'b0;
      rdata_p1 <= '0;
      wword_p1 <= '0;
    end else begin
      state_q <= state_d;
      // p0: request accepted in IDLE; stale load data is cleared so stores/errors return 0
      if (state_q == IDLE && bus.req_valid) begin
        op_p0    <= bus.op;
        addr_p0  <= bus.addr;
        wdata_p0 <= bus.wdata;
        err_p0   <= acc_err;
        rdata_p1 <= '0;
        wword_p1 <= bus.wdata;
      end
      // p1: memory word captured in RD, either as load result or as merged store word
      if (state_q == RD) begin
        if (rmw_p0) wword_p1 <= store_merge(op_p0, addr_p0[1:0], bus.ReadData, wdata_p0);
        else        rdata_p1 <= load_extend(op_p0, addr_p0[1:0], bus.ReadData);
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.MemRead    = (state_q == RD);
  assign bus.MemWrite   = (state_q == WR);
  assign bus.Address    = {addr_p0[31:2], 2'b00};
  assign bus.WriteData  = wword_p1;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_p0;
  assign bus.rdata      = (state_q == RESP) ? rdata_p1 : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-addressed reference memory.
module tb_load_store_unit;
  logic clock;
  logic reset_n;
  load_store_unit_if bus();

  load_store_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h80FF7F01;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Word memory seen by the DUT; written only by this process.
  logic [31:0] mem [0:63];
  assign bus.ReadData = mem[bus.Address[7:2]];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clock);
      if (bus.MemWrite) mem[bus.Address[7:2]] = bus.WriteData;
    end
  end

  // Reference model: flat byte array, little-endian.
  logic [7:0] ref_mem [0:255];

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          exp_cyc;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
  } exp_t;
  exp_t q[$];

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                       output exp_t e, output int lat);
    int size, off;
    longint v;
    bit load, signd;
    size  = (o == 3'd0 || o == 3'd5) ? 4 : (o == 3'd1 || o == 3'd2 || o == 3'd6) ? 1 : 2;
    load  = (o < 3'd5);
    signd = (o == 3'd1 || o == 3'd3);
    off   = int'(a[7:0]);
    e.err = (off % size) != 0;
    e.rdata = 32'h0;
    e.waddr = {a[31:2], 2'b00};
    e.nrd = 0;
    e.nwr = 0;
    if (e.err) begin
      lat = 1;
    end else if (load) begin
      v = 0;
      for (int i = 0; i < size; i++) v += longint'(ref_mem[off + i]) << (8 * i);
      if (signd && v >= (longint'(1) << (8 * size - 1))) v -= (longint'(1) << (8 * size));
      e.rdata = 32'(v);
      e.nrd = 1;
      lat = 2;
    end else begin
      for (int i = 0; i < size; i++) ref_mem[off + i] = 8'(d >> (8 * i));
      e.nwr = 1;
      e.nrd = (size == 4) ? 0 : 1;
      lat   = (size == 4) ? 2 : 3;
    end
  endtask

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "aborted");
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with req_valid still high.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int lat;
    int n = 0;
    bus.req_valid = 1'b1;
    bus.op = o;
    bus.addr = a;
    bus.wdata = d;
    while (bus.req_ready !== 1'b1) begin
      @(negedge clock);
      n++;
      if (n > 50) begin
        mismatched++;
        $display("FAIL accept_timeout: got ready=%b expected 1", bus.req_ready);
        finish_now();
      end
    end
    model(o, a, d, e, lat);
    e.exp_cyc = cyc + lat;
    q.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drain();
    int n = 0;
    bus.req_valid = 1'b0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(negedge clock);
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each response.
  int rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_addr = 32'h0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (bus.MemRead)  begin rd_cnt++; last_addr = bus.Address; end
        if (bus.MemWrite) begin wr_cnt++; last_addr = bus.Address; end
        chk("protocol", {29'h0, bus.MemRead && bus.MemWrite,
                         bus.req_ready && (bus.MemRead || bus.MemWrite),
                         bus.req_ready && bus.resp_valid}, 32'h0);
        if (bus.resp_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_resp", 32'h1, 32'h0);
          end else begin
            e = q.pop_front();
            chk("resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
            chk("rdata", bus.rdata, e.rdata);
            chk("latency", cyc, e.exp_cyc);
            chk("mem_reads", rd_cnt, e.nrd);
            chk("mem_writes", wr_cnt, e.nwr);
            if (e.nrd + e.nwr > 0) chk("address", last_addr, e.waddr);
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    mismatched++;
    $display("FAIL watchdog: got timeout expected completion");
    finish_now();
  end

  initial begin
    logic [31:0] pre, r, a, w;
    logic [7:0]  lo;
    logic [2:0]  o;
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.op = 3'b000;
    bus.addr = 32'h0;
    bus.wdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      w = init_word(i);
      for (int j = 0; j < 4; j++) ref_mem[4 * i + j] = 8'(w >> (8 * j));
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_memrw", {30'h0, bus.MemRead, bus.MemWrite}, 32'h0);
    chk("rst_address", bus.Address, 32'h0);
    chk("rst_writedata", bus.WriteData, 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);

    // Directed loads on 0x80FF7F01, back-to-back with req_valid held high.
    issue(3'b001, 32'h12, 32'h0);
    issue(3'b010, 32'h12, 32'h0);
    issue(3'b011, 32'h12, 32'h0);
    issue(3'b100, 32'h12, 32'h0);
    issue(3'b000, 32'h10, 32'h0);
    issue(3'b110, 32'h11, 32'h000000AB);
    drain();
    chk("sb_word", mem[4], 32'h80FFAB01);
    issue(3'b101, 32'h10, 32'h80FF7F01);
    issue(3'b111, 32'h12, 32'h00001234);
    drain();
    chk("sh_word", mem[4], 32'h12347F01);
    issue(3'b101, 32'h10, 32'hDEADBEEF);
    issue(3'b000, 32'h10, 32'h0);
    issue(3'b000, 32'h12, 32'h0);
    issue(3'b111, 32'h11, 32'h0000FFFF);
    issue(3'b100, 32'h13, 32'h0);
    drain();
    chk("sw_word", mem[4], 32'hDEADBEEF);

    // Reset sampled at the end of RD of an SB aborts it.
    pre = mem[4];
    bus.op = 3'b110;
    bus.addr = 32'h11;
    bus.wdata = 32'h000000AB;
    bus.req_valid = 1'b1;
    chk("abort_ready_before", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("abort_in_rd", {31'h0, bus.MemRead}, 32'h1);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("abort_ready_after", {31'h0, bus.req_ready}, 32'h1);
    chk("abort_no_write", {31'h0, bus.MemWrite}, 32'h0);
    chk("abort_no_resp", {31'h0, bus.resp_valid}, 32'h0);
    chk("abort_address", bus.Address, 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("abort_word", mem[4], pre);

    // Randomized mix with occasional idle gaps.
    for (int k = 0; k < 300; k++) begin
      o  = 3'($urandom_range(0, 7));
      r  = $urandom;
      lo = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) lo[1:0] = 2'b00;
      a  = {r[31:8], lo};
      if ($urandom_range(0, 3) == 0) begin
        bus.req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
      end
      issue(o, a, $urandom);
    end
    drain();

    for (int i = 0; i < 64; i++)
      chk("final_mem", mem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state changes on posedge clock.
REQ-002 clock  in  1  system clock.
REQ-003 reset_n  in  1  synchronous active-low reset, sampled on posedge clock.
REQ-004 req_valid  in  1  core presents an access request.
REQ-005 req_ready  out  1  unit idle and able to accept a request.
REQ-006 op  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH.
REQ-007 addr  in  32  byte address.
REQ-008 wdata  in  32  store data; SB uses [7:0], SH uses [15:0].
REQ-009 resp_valid  out  1  one-cycle completion pulse.
REQ-010 resp_err  out  1  misaligned access; valid with resp_valid.
REQ-011 rdata  out  32  extended load result; valid with resp_valid.
REQ-012 MemRead  out  1  word-memory read enable.
REQ-013 MemWrite  out  1  word-memory write enable; the memory writes on posedge.
REQ-014 Address  out  32  word-aligned memory address.
REQ-015 WriteData  out  32  word to store.
REQ-016 ReadData  in  32  word from memory, combinationally valid while MemRead=1.

Function
REQ-017 SHALL implement states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-018 Handshake: in IDLE, req_valid=1 latches op, addr and wdata at the edge; inputs are ignored in every other state.
REQ-019 Alignment: LW/SW need addr[1:0]=00; LH/LHU/SH need addr[0]=0; bytes are always aligned.
REQ-020 Misaligned request: IDLE->RESP with resp_err=1 and rdata=0; no MemRead or MemWrite is ever asserted.
REQ-021 Loads: IDLE->RD->RESP; in RD, MemRead=1 and the extracted and extended result is registered at the end of the RD cycle.
REQ-022 SW: IDLE->WR->RESP; in WR, MemWrite=1 and WriteData=latched wdata.
REQ-023 SB/SH (read-modify-write): IDLE->RD->WR->RESP; the RD word is captured, the target byte/halfword is replaced, and the merged word is driven in WR.
REQ-024 Byte order is little-endian: lane k = addr[1:0] selects bits [8k+7:8k]; the halfword at addr[1] selects bits [16*addr[1]+15:16*addr[1]].
REQ-025 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW passes the word unchanged.
REQ-026 Address={latched addr[31:2],2'b00} in every state after acceptance; Address holds its value in IDLE.
REQ-027 MemRead and MemWrite are never high in the same cycle; both are 0 outside RD and WR respectively.
REQ-028 RESP lasts exactly one cycle, asserting resp_valid=1, then returns to IDLE; resp_err=0 for aligned accesses; rdata=0 for stores.
REQ-029 Latency from the acceptance edge to the resp_valid cycle: misaligned 1, LW/Lx/SW 2, SB/SH 3.
REQ-030 A new request may be accepted on the edge that leaves RESP only if req_ready was high, so no accept occurs during RESP.

Reset
REQ-031 reset_n=0 at a posedge forces IDLE. It also clears resp_valid, resp_err, rdata, MemRead, MemWrite, Address, WriteData and the latched request to 0; req_ready=1.
REQ-032 Reset mid-operation aborts the access with no RESP. A WR cycle ending on the reset edge is committed by memory; no MemWrite is asserted after that edge.
REQ-033 reset_n has priority over req_valid on the same edge.

Verification
REQ-034 Word 0x10 = 0x80FF7F01. Expected results: LB 0x12 -> rdata 0xFFFFFFFF; LBU 0x12 -> 0x000000FF; LH 0x12 -> 0xFFFF80FF; LHU 0x12 -> 0x000080FF; LW 0x10 -> 0x80FF7F01. Each response SHALL arrive 2 cycles after acceptance.
REQ-035 SB 0x11 with wdata 0x000000AB SHALL give cycles RD, WR, RESP. Memory word 0x10 becomes 0x80FFAB01, and resp_valid appears 3 cycles after acceptance.
REQ-036 SH 0x12 with wdata 0x00001234 on 0x80FF7F01 SHALL leave the word at 0x12347F01; SW 0x10 with 0xDEADBEEF followed by LW 0x10 SHALL return 0xDEADBEEF.
REQ-037 LW 0x12, SH 0x11 and LHU 0x13 SHALL each give resp_valid=1 and resp_err=1 one cycle after acceptance, with rdata=0 and no MemRead or MemWrite.
REQ-038 SB 0x11 with reset_n=0 sampled at the end of RD: the next state is IDLE, req_ready=1, no MemWrite occurs, no resp_valid occurs, and word 0x10 is unchanged.
REQ-039 req_valid held high for SW then LW: req_ready=0 throughout RD/WR/RESP; exactly one request is accepted per IDLE; no request is lost or duplicated.
